// File: rtl/dma_c2h_pattern_gen.sv
// C2H AXI4-Stream pattern generator: emits fixed-length packets whose beats carry
// {packet number, beat counter}, with a packet-boundary stop on abort or link loss.
module dma_c2h_pattern_gen #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                    user_clk,
    input  logic                    user_resetn,
    input  logic                    user_lnk_up,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LEN_WIDTH-1:0]    pkt_len_beats,
    input  logic [LEN_WIDTH-1:0]    pkt_count,
    output logic [DATA_WIDTH-1:0]   m_axis_c2h_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_c2h_tkeep,
    output logic                    m_axis_c2h_tlast,
    output logic                    m_axis_c2h_tvalid,
    input  logic                    m_axis_c2h_tready,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             pkts_sent
);

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    state_e state_q, state_d;

    logic [LEN_WIDTH-1:0] len_last_q, len_last_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [LEN_WIDTH-1:0] beat_in_pkt_q, beat_in_pkt_d;
    logic [LEN_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0]          beat_cnt_q, beat_cnt_d;
    logic [31:0]          pkt_num_q, pkt_num_d;
    logic [31:0]          pkts_sent_q, pkts_sent_d;
    logic                 stop_q, stop_d;
    logic                 done_q, done_d;

    logic start_ok;
    logic handshake;
    logic is_last;
    logic last_hs;
    logic stop_now;
    logic run_done;
    logic leave_send;

    assign start_ok  = (state_q == StIdle) && start && user_lnk_up && !abort;
    assign handshake = m_axis_c2h_tvalid && m_axis_c2h_tready;
    assign is_last   = (beat_in_pkt_q == len_last_q);
    assign last_hs   = handshake && is_last;
    // A stop seen in the same cycle as the closing beat also counts, so the next
    // packet is never presented.
    assign stop_now  = stop_q || abort || !user_lnk_up;
    assign run_done  = (count_q != '0) && (pkt_cnt_q == count_q - LEN_WIDTH'(1));
    assign leave_send = last_hs && (stop_now || run_done);

    // State register
    always_ff @(posedge user_clk or negedge user_resetn) begin
        if (!user_resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (leave_send) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        m_axis_c2h_tvalid = (state_q == StSend);
        m_axis_c2h_tlast  = m_axis_c2h_tvalid && is_last;
        m_axis_c2h_tkeep  = {(DATA_WIDTH/8){m_axis_c2h_tvalid}};
        m_axis_c2h_tdata  = {pkt_num_q, beat_cnt_q};
        busy              = (state_q == StSend);
        done              = done_q;
        pkts_sent         = pkts_sent_q;
    end

    // Datapath next-state: counters only move on a handshake, which keeps the
    // presented beat stable under backpressure.
    always_comb begin
        len_last_d    = len_last_q;
        count_d       = count_q;
        beat_in_pkt_d = beat_in_pkt_q;
        pkt_cnt_d     = pkt_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        pkt_num_d     = pkt_num_q;
        pkts_sent_d   = pkts_sent_q;
        stop_d        = stop_q;
        done_d        = leave_send;

        if (start_ok) begin
            len_last_d    = (pkt_len_beats == '0) ? '0 : pkt_len_beats - LEN_WIDTH'(1);
            count_d       = pkt_count;
            beat_in_pkt_d = '0;
            pkt_cnt_d     = '0;
            beat_cnt_d    = '0;
            pkt_num_d     = '0;
            pkts_sent_d   = '0;
            stop_d        = 1'b0;
        end else if (state_q == StSend) begin
            if (abort || !user_lnk_up) begin
                stop_d = 1'b1;
            end
            if (handshake) begin
                beat_cnt_d = beat_cnt_q + 32'd1;
                if (is_last) begin
                    beat_in_pkt_d = '0;
                    pkt_cnt_d     = pkt_cnt_q + LEN_WIDTH'(1);
                    pkt_num_d     = pkt_num_q + 32'd1;
                    pkts_sent_d   = pkts_sent_q + 32'd1;
                end else begin
                    beat_in_pkt_d = beat_in_pkt_q + LEN_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge user_clk or negedge user_resetn) begin
        if (!user_resetn) begin
            len_last_q    <= '0;
            count_q       <= '0;
            beat_in_pkt_q <= '0;
            pkt_cnt_q     <= '0;
            beat_cnt_q    <= '0;
            pkt_num_q     <= '0;
            pkts_sent_q   <= '0;
            stop_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            len_last_q    <= len_last_d;
            count_q       <= count_d;
            beat_in_pkt_q <= beat_in_pkt_d;
            pkt_cnt_q     <= pkt_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            pkt_num_q     <= pkt_num_d;
            pkts_sent_q   <= pkts_sent_d;
            stop_q        <= stop_d;
            done_q        <= done_d;
        end
    end

endmodule

// File: tb/tb_dma_c2h_pattern_gen.sv
// Directed bench for dma_c2h_pattern_gen: inputs change and outputs are sampled on
// the falling edge; a handshake happens on the following rising edge.
module tb_dma_c2h_pattern_gen;

    logic        clk;
    logic        rst_n;
    logic        lnk_up;
    logic        start;
    logic        abort;
    logic [15:0] pkt_len_beats;
    logic [15:0] pkt_count;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    logic        busy;
    logic        done;
    logic [31:0] pkts_sent;

    int checks;
    int failures;

    dma_c2h_pattern_gen #(
        .DATA_WIDTH(64),
        .LEN_WIDTH (16)
    ) dut (
        .user_clk         (clk),
        .user_resetn      (rst_n),
        .user_lnk_up      (lnk_up),
        .start            (start),
        .abort            (abort),
        .pkt_len_beats    (pkt_len_beats),
        .pkt_count        (pkt_count),
        .m_axis_c2h_tdata (tdata),
        .m_axis_c2h_tkeep (tkeep),
        .m_axis_c2h_tlast (tlast),
        .m_axis_c2h_tvalid(tvalid),
        .m_axis_c2h_tready(tready),
        .busy             (busy),
        .done             (done),
        .pkts_sent        (pkts_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns at the falling edge just after the start was sampled.
    task automatic pulse_start(input logic [15:0] len, input logic [15:0] cnt);
        @(negedge clk);
        pkt_len_beats = len;
        pkt_count     = cnt;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
        checks++; if (tdata !== 64'd0) begin failures++; $display("FAIL reset_tdata got %h want 0", tdata); end
        checks++; if (tkeep !== 8'h00 || tlast !== 1'b0) begin failures++; $display("FAIL reset_tkeep_tlast got %h/%b want 00/0", tkeep, tlast); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got %b/%b want 0/0", busy, done); end
        checks++; if (pkts_sent !== 32'd0) begin failures++; $display("FAIL reset_pkts_sent got %0d want 0", pkts_sent); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (tvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_idle got tvalid=%b busy=%b want 0/0", tvalid, busy); end
    endtask

    task automatic test_basic;
        logic [63:0] exp;
        tready = 1'b1;
        pulse_start(16'd4, 16'd2);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got %b want 1", busy); end
        checks++; if (tkeep !== 8'hFF) begin failures++; $display("FAIL basic_tkeep got %h want ff", tkeep); end
        for (int i = 0; i < 8; i++) begin
            exp = {32'(i / 4), 32'(i)};
            checks++; if (tvalid !== 1'b1) begin failures++; $display("FAIL basic_tvalid beat %0d got %b want 1", i, tvalid); end
            checks++; if (tdata !== exp) begin failures++; $display("FAIL basic_tdata beat %0d got %h want %h", i, tdata, exp); end
            checks++; if (tlast !== 1'((i % 4) == 3)) begin failures++; $display("FAIL basic_tlast beat %0d got %b want %b", i, tlast, (i % 4) == 3); end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || tvalid !== 1'b0) begin failures++; $display("FAIL basic_done got done=%b tvalid=%b want 1/0", done, tvalid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got %b want 0", busy); end
        checks++; if (pkts_sent !== 32'd2) begin failures++; $display("FAIL basic_pkts_sent got %0d want 2", pkts_sent); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_width got %b want 0", done); end
    endtask

    task automatic test_backpressure;
        logic [5:0] pat;
        int hs;
        pat = 6'b101001; // bit k is tready in cycle k: 1,0,0,1,0,1
        hs  = 0;
        tready = 1'b1;
        pulse_start(16'd3, 16'd1);
        for (int k = 0; k < 6; k++) begin
            tready = pat[k];
            checks++; if (tvalid !== 1'b1) begin failures++; $display("FAIL bp_tvalid cycle %0d got %b want 1", k, tvalid); end
            checks++; if (tdata !== {32'd0, 32'(hs)}) begin failures++; $display("FAIL bp_tdata cycle %0d got %h want %h", k, tdata, {32'd0, 32'(hs)}); end
            checks++; if (tlast !== 1'(hs == 2)) begin failures++; $display("FAIL bp_tlast cycle %0d got %b want %b", k, tlast, hs == 2); end
            if (pat[k]) hs++;
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || tvalid !== 1'b0) begin failures++; $display("FAIL bp_done got done=%b tvalid=%b want 1/0", done, tvalid); end
        checks++; if (pkts_sent !== 32'd1) begin failures++; $display("FAIL bp_pkts_sent got %0d want 1", pkts_sent); end
        tready = 1'b1;
    endtask

    task automatic test_abort;
        logic [63:0] exp;
        tready = 1'b1;
        pulse_start(16'd5, 16'd0);
        for (int i = 0; i < 10; i++) begin
            if (i == 7) abort = 1'b1;
            exp = {32'(i / 5), 32'(i)};
            checks++; if (tvalid !== 1'b1 || tdata !== exp) begin failures++; $display("FAIL abort_beat %0d got v=%b d=%h want 1/%h", i, tvalid, tdata, exp); end
            checks++; if (tlast !== 1'((i % 5) == 4)) begin failures++; $display("FAIL abort_tlast beat %0d got %b want %b", i, tlast, (i % 5) == 4); end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || tvalid !== 1'b0) begin failures++; $display("FAIL abort_done got done=%b tvalid=%b want 1/0", done, tvalid); end
        checks++; if (pkts_sent !== 32'd2) begin failures++; $display("FAIL abort_pkts_sent got %0d want 2", pkts_sent); end
        abort = 1'b0;
        @(negedge clk);
        checks++; if (tvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_idle got tvalid=%b busy=%b want 0/0", tvalid, busy); end
    endtask

    task automatic test_zero_len;
        tready = 1'b1;
        pulse_start(16'd0, 16'd3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (tvalid !== 1'b1 || tdata !== {32'(i), 32'(i)}) begin failures++; $display("FAIL zlen_beat %0d got v=%b d=%h want 1/%h", i, tvalid, tdata, {32'(i), 32'(i)}); end
            checks++; if (tlast !== 1'b1) begin failures++; $display("FAIL zlen_tlast beat %0d got %b want 1", i, tlast); end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || pkts_sent !== 32'd3) begin failures++; $display("FAIL zlen_end got done=%b pkts=%0d want 1/3", done, pkts_sent); end
    endtask

    task automatic test_ignored_start;
        tready = 1'b1;
        pulse_start(16'd4, 16'd1);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                pkt_len_beats = 16'd2;
                pkt_count     = 16'd5;
                start         = 1'b1;
            end else begin
                start = 1'b0;
            end
            checks++; if (tvalid !== 1'b1 || tdata !== {32'd0, 32'(i)}) begin failures++; $display("FAIL busy_start beat %0d got v=%b d=%h want 1/%h", i, tvalid, tdata, {32'd0, 32'(i)}); end
            checks++; if (tlast !== 1'(i == 3)) begin failures++; $display("FAIL busy_start_tlast beat %0d got %b want %b", i, tlast, i == 3); end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || pkts_sent !== 32'd1) begin failures++; $display("FAIL busy_start_end got done=%b pkts=%0d want 1/1", done, pkts_sent); end
        lnk_up = 1'b0;
        pulse_start(16'd2, 16'd1);
        checks++; if (tvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL lnk_down_start got tvalid=%b busy=%b want 0/0", tvalid, busy); end
        checks++; if (pkts_sent !== 32'd1) begin failures++; $display("FAIL lnk_down_pkts got %0d want 1", pkts_sent); end
        lnk_up = 1'b1;
        @(negedge clk);
        checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL lnk_down_later got tvalid=%b want 0", tvalid); end
    endtask

    task automatic test_reset_mid;
        tready = 1'b1;
        pulse_start(16'd4, 16'd1);
        @(negedge clk);
        @(negedge clk);
        checks++; if (tvalid !== 1'b1 || tdata !== 64'd2) begin failures++; $display("FAIL rstmid_pre got v=%b d=%h want 1/2", tvalid, tdata); end
        rst_n = 1'b0;
        #1;
        checks++; if (tvalid !== 1'b0 || tdata !== 64'd0) begin failures++; $display("FAIL rstmid_stream got v=%b d=%h want 0/0", tvalid, tdata); end
        checks++; if (tkeep !== 8'h00 || tlast !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got keep=%h last=%b busy=%b done=%b want 00/0/0/0", tkeep, tlast, busy, done); end
        checks++; if (pkts_sent !== 32'd0) begin failures++; $display("FAIL rstmid_pkts got %0d want 0", pkts_sent); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_idle got tvalid=%b want 0", tvalid); end
        pulse_start(16'd2, 16'd1);
        checks++; if (tvalid !== 1'b1 || tdata !== 64'd0 || tlast !== 1'b0) begin failures++; $display("FAIL rstmid_restart0 got v=%b d=%h l=%b want 1/0/0", tvalid, tdata, tlast); end
        @(negedge clk);
        checks++; if (tvalid !== 1'b1 || tdata !== 64'd1 || tlast !== 1'b1) begin failures++; $display("FAIL rstmid_restart1 got v=%b d=%h l=%b want 1/1/1", tvalid, tdata, tlast); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || pkts_sent !== 32'd1) begin failures++; $display("FAIL rstmid_done got done=%b pkts=%0d want 1/1", done, pkts_sent); end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        lnk_up        = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        pkt_len_beats = 16'd0;
        pkt_count     = 16'd0;
        tready        = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_zero_len();
        test_ignored_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
